// File: rtl/flag_jump_unit.sv
// -----------------------------------------------------------------------------
// flag_jump_unit
//
// Two-stage pipelined flag and jump evaluator that sits after the ALU.
// Stage 1 registers the ALU word, its jump field, its MSB and a per-byte
// non-zero vector. Each bit of that vector is an 8-input OR of one byte.
// Stage 2 ORs the byte vector to form zr, takes ng from the MSB and
// evaluates the jump condition. Both sides use a valid/ready handshake, so a
// downstream stall propagates back to in_ready in the same cycle.
//
// Parameters:
//   WIDTH  data word width; must be a multiple of 8 and at least 8
//   CNT_W  width of the taken-jump counter (JMP_STATS_EN builds only)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   upstream word valid
//   in_ready   unit can accept a word this cycle
//   in_data    ALU result
//   in_jmp     jump field {lt, eq, gt}
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   out_data   in_data delayed by two stages
//   out_zr     word equals zero
//   out_ng     word MSB is set
//   out_jump   jump taken
//   cnt_clr    (JMP_STATS_EN) synchronous clear of taken_cnt
//   taken_cnt  (JMP_STATS_EN) saturating count of taken jumps handed off
//
// Optional feature macro: JMP_STATS_EN. It adds the taken-jump counter.
// -----------------------------------------------------------------------------
module flag_jump_unit #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [2:0]       in_jmp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zr,
    output logic             out_ng,
    output logic             out_jump
`ifdef JMP_STATS_EN
    ,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] taken_cnt
`endif
);

    localparam int NBYTES = WIDTH / 8;

    // Stage 1 state
    logic              s1_valid_reg;
    logic [WIDTH-1:0]  s1_data_reg;
    logic [2:0]        s1_jmp_reg;
    logic              s1_msb_reg;
    logic [NBYTES-1:0] s1_nz_reg;

    // Stage 2 state (drives the outputs directly)
    logic              s2_valid_reg;
    logic [WIDTH-1:0]  s2_data_reg;
    logic              s2_zr_reg;
    logic              s2_ng_reg;
    logic              s2_jump_reg;

    // Handshake and combinational next values
    logic              s1_adv;
    logic              s2_adv;
    logic [NBYTES-1:0] byte_nz_next;
    logic              zr_next;
    logic              ng_next;
    logic              jump_next;

    // Per-byte 8-input OR, the same structure as an or8way gate.
    genvar gi;
    generate
        for (gi = 0; gi < NBYTES; gi++) begin : g_byte_or
            assign byte_nz_next[gi] = |in_data[gi*8 +: 8];
        end
    endgenerate

    // A stage may advance when it is empty or the stage after it advances.
    assign s2_adv   = !s2_valid_reg || out_ready;
    assign s1_adv   = !s1_valid_reg || s2_adv;
    assign in_ready = s1_adv;

    // Flags are computed from the stage-1 registers and loaded into stage 2.
    // jmp[2] is lt, jmp[1] is eq and jmp[0] is gt.
    assign zr_next   = ~|s1_nz_reg;
    assign ng_next   = s1_msb_reg;
    assign jump_next = (s1_jmp_reg[2] & ng_next)
                     | (s1_jmp_reg[1] & zr_next)
                     | (s1_jmp_reg[0] & ~zr_next & ~ng_next);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_data_reg  <= '0;
            s1_jmp_reg   <= '0;
            s1_msb_reg   <= 1'b0;
            s1_nz_reg    <= '0;
        end else if (s1_adv) begin
            s1_valid_reg <= in_valid;
            if (in_valid) begin
                s1_data_reg <= in_data;
                s1_jmp_reg  <= in_jmp;
                s1_msb_reg  <= in_data[WIDTH-1];
                s1_nz_reg   <= byte_nz_next;
            end
        end
    end

    // When stage 2 takes in a bubble, the payload keeps its previous value.
    // Only the valid flag moves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_reg <= 1'b0;
            s2_data_reg  <= '0;
            s2_zr_reg    <= 1'b0;
            s2_ng_reg    <= 1'b0;
            s2_jump_reg  <= 1'b0;
        end else if (s2_adv) begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                s2_data_reg <= s1_data_reg;
                s2_zr_reg   <= zr_next;
                s2_ng_reg   <= ng_next;
                s2_jump_reg <= jump_next;
            end
        end
    end

    assign out_valid = s2_valid_reg;
    assign out_data  = s2_data_reg;
    assign out_zr    = s2_zr_reg;
    assign out_ng    = s2_ng_reg;
    assign out_jump  = s2_jump_reg;

`ifdef JMP_STATS_EN
    logic [CNT_W-1:0] taken_cnt_reg;

    // A clear takes priority over an increment in the same cycle.
    // The count saturates at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taken_cnt_reg <= '0;
        end else if (cnt_clr) begin
            taken_cnt_reg <= '0;
        end else if (s2_valid_reg && out_ready && s2_jump_reg && !(&taken_cnt_reg)) begin
            taken_cnt_reg <= taken_cnt_reg + 1'b1;
        end
    end

    assign taken_cnt = taken_cnt_reg;
`endif

endmodule

// File: tb/tb_flag_jump_unit.sv
module tb_flag_jump_unit;

    localparam int WIDTH = 16;
`ifdef JMP_STATS_EN
    localparam int CNT_W = 2;
`else
    localparam int CNT_W = 16;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic [2:0]       in_jmp = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic             out_zr;
    logic             out_ng;
    logic             out_jump;
`ifdef JMP_STATS_EN
    logic             cnt_clr = 1'b0;
    logic [CNT_W-1:0] taken_cnt;
`endif

    flag_jump_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_jmp    (in_jmp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_zr    (out_zr),
        .out_ng    (out_ng),
        .out_jump  (out_jump)
`ifdef JMP_STATS_EN
        ,
        .cnt_clr   (cnt_clr),
        .taken_cnt (taken_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             zr;
        logic             ng;
        logic             jump;
        int               cyc;
        bit               lat;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    bit   lat_chk = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: flags from the word's signed value.
    function automatic exp_t model(input logic [WIDTH-1:0] d, input logic [2:0] j);
        exp_t e;
        bit lt, eq, gt;
        lt = $signed(d) < 0;
        eq = (d == 0);
        gt = $signed(d) > 0;
        e.data = d;
        e.zr   = eq;
        e.ng   = lt;
        e.jump = (j[2] && lt) || (j[1] && eq) || (j[0] && gt);
        e.cyc  = 0;
        e.lat  = 1'b0;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // One cycle of stimulus, starting and ending just after a rising edge.
    // If use_exp is set, the expected flags come from the arguments.
    // Otherwise they come from the model.
    task automatic cycle_drive(input logic v, input logic [WIDTH-1:0] d, input logic [2:0] j,
                               input logic r, input bit use_exp,
                               input logic ezr, input logic eng, input logic ejmp);
        exp_t e;
        in_valid  = v;
        in_data   = d;
        in_jmp    = j;
        out_ready = r;
        @(negedge clk);
        if (in_valid && in_ready) begin
            e = model(d, j);
            if (use_exp) begin
                e.zr   = ezr;
                e.ng   = eng;
                e.jump = ejmp;
            end
            e.cyc = cyc;
            e.lat = lat_chk;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic [2:0] j, input logic r);
        cycle_drive(v, d, j, r, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic dstep(input logic v, input logic [WIDTH-1:0] d, input logic [2:0] j, input logic r,
                         input logic ezr, input logic eng, input logic ejmp);
        cycle_drive(v, d, j, r, 1'b1, ezr, eng, ejmp);
    endtask

    // Monitor: pops the scoreboard on each output handshake and checks that
    // the outputs hold during a stall.
    logic             prev_stall = 1'b0;
    logic [WIDTH-1:0] prev_data;
    logic             prev_zr, prev_ng, prev_jump;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                n_tests++;
                if (!out_valid || out_data !== prev_data || out_zr !== prev_zr ||
                    out_ng !== prev_ng || out_jump !== prev_jump) begin
                    n_fail++;
                    $display("[TB] FAIL hold: got v=%b d=%h zr=%b ng=%b j=%b, expected v=1 d=%h zr=%b ng=%b j=%b",
                             out_valid, out_data, out_zr, out_ng, out_jump,
                             prev_data, prev_zr, prev_ng, prev_jump);
                end
            end
            if (out_valid && out_ready) begin
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("[TB] FAIL unexpected_beat: got d=%h, expected no beat", out_data);
                end else begin
                    e = sb.pop_front();
                    $display("[TB] beat d=%h zr=%b ng=%b jump=%b (exp d=%h zr=%b ng=%b jump=%b)",
                             out_data, out_zr, out_ng, out_jump, e.data, e.zr, e.ng, e.jump);
                    if (out_data !== e.data || out_zr !== e.zr || out_ng !== e.ng || out_jump !== e.jump) begin
                        n_fail++;
                        $display("[TB] FAIL beat: got d=%h zr=%b ng=%b j=%b, expected d=%h zr=%b ng=%b j=%b",
                                 out_data, out_zr, out_ng, out_jump, e.data, e.zr, e.ng, e.jump);
                    end
                    if (e.lat) begin
                        n_tests++;
                        if (cyc - e.cyc != 2) begin
                            n_fail++;
                            $display("[TB] FAIL latency: got %0d, expected 2", cyc - e.cyc);
                        end
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_zr    = out_zr;
            prev_ng    = out_ng;
            prev_jump  = out_jump;
        end
    end

    initial begin
        logic [WIDTH-1:0] d;

        // Reset state
        repeat (2) @(posedge clk);
        #2;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_data", {16'b0, out_data}, 32'd0);
        check("rst_flags", {29'b0, out_zr, out_ng, out_jump}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);

        // Directed flag and jump stream under continuous flow
        lat_chk = 1'b1;
        dstep(1, 16'h0000, 3'b010, 1, 1, 0, 1);
        dstep(1, 16'h8000, 3'b100, 1, 0, 1, 1);
        dstep(1, 16'h0001, 3'b001, 1, 0, 0, 1);
        dstep(1, 16'h0100, 3'b010, 1, 0, 0, 0);
        dstep(1, 16'hFFFF, 3'b000, 1, 0, 1, 0);
        dstep(1, 16'h0000, 3'b000, 1, 1, 0, 0);
        dstep(1, 16'hFFFF, 3'b111, 1, 0, 1, 1);
        dstep(1, 16'h0000, 3'b111, 1, 1, 0, 1);
        repeat (3) step(0, 16'h0, 3'b000, 1);
        lat_chk = 1'b0;
        check("stream_drained", sb.size(), 32'd0);

        // Backpressure: fill both stages while downstream stalls
        dstep(1, 16'h0005, 3'b000, 0, 0, 0, 0);
        dstep(1, 16'h0006, 3'b000, 0, 0, 0, 0);
        in_valid = 1'b1;
        in_data  = 16'h0007;
        out_ready = 1'b0;
        @(negedge clk);
        check("bp_in_ready", {31'b0, in_ready}, 32'd0);
        check("bp_out_valid", {31'b0, out_valid}, 32'd1);
        check("bp_out_data", {16'b0, out_data}, 32'h0005);
        @(posedge clk);
        #1;
        repeat (4) step(0, 16'h0, 3'b000, 1);
        check("bp_drained", sb.size(), 32'd0);

        // Reset with both stages full
        dstep(1, 16'h0009, 3'b111, 0, 0, 0, 1);
        dstep(1, 16'h000A, 3'b111, 0, 0, 0, 1);
        rst_n = 1'b0;
        sb.delete();
        #2;
        check("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("mid_rst_out_data", {16'b0, out_data}, 32'd0);
        check("mid_rst_flags", {29'b0, out_zr, out_ng, out_jump}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
        repeat (4) step(0, 16'h0, 3'b000, 1);
        check("mid_rst_no_residual", {31'b0, out_valid}, 32'd0);

`ifdef JMP_STATS_EN
        // Saturating taken-jump counter
        for (int k = 1; k <= 5; k++) begin
            dstep(1, 16'h0003, 3'b111, 1, 0, 0, 1);
            repeat (3) step(0, 16'h0, 3'b000, 1);
            check($sformatf("taken_cnt_%0d", k), {30'b0, taken_cnt}, (k > 3) ? 32'd3 : k);
        end
        cnt_clr = 1'b1;
        step(0, 16'h0, 3'b000, 1);
        cnt_clr = 1'b0;
        check("taken_cnt_clr", {30'b0, taken_cnt}, 32'd0);
`endif

        // Randomized traffic with random backpressure
        for (int i = 0; i < 1500; i++) begin
            case ($urandom_range(0, 3))
                0:       d = 16'h0000;
                1:       d = 16'h8000 | 16'($urandom);
                2:       d = 16'($urandom);
                default: d = 16'h0001 << $urandom_range(0, 15);
            endcase
            step(1'($urandom_range(0, 1)), d, 3'($urandom), 1'($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < 6; i++) step(0, 16'h0, 3'b000, 1);
        check("random_drained", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/flag_jump_unit.md
Name: flag_jump_unit

Overview:
- Two-stage pipelined flag and jump evaluator placed directly downstream of the ALU output in the CPU datapath.
- Zero detection is a per-byte 8-input OR reduction followed by an OR across bytes, so it uses the same structure as the or8way gate.
- Registers the ALU word and produces the Hack flags zr and ng, plus the jump decision for a 3-bit jump field.
- Uses a valid/ready handshake on both sides, so stalls propagate cleanly into the PC load logic.

Parameters:
- WIDTH, 16, data word width; must be a multiple of 8 and at least 8.
- CNT_W, 16, width of the taken-jump counter (used only when JMP_STATS_EN is defined).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  unit can accept a word this cycle.
- in_data  input  WIDTH  ALU result.
- in_jmp  input  3  jump field j1 j2 j3 as [2:0] = {lt, eq, gt}.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_data  output  WIDTH  in_data delayed two stages.
- out_zr  output  1  1 when the word equals 0.
- out_ng  output  1  1 when the word MSB is 1.
- out_jump  output  1  jump taken.

Behaviour:
- Reset: asynchronous on rst_n low. s1_valid, s2_valid, out_valid, out_data, out_zr, out_ng and out_jump all go to 0. in_ready reads 1 once rst_n is high.
- Reset mid-operation: all in-flight words are discarded. No output beat appears for them after release.
- Stage advance conditions:
  - s2_adv = !s2_valid | out_ready.
  - s1_adv = !s1_valid | s2_adv.
  - in_ready = s1_adv (combinational, no dependence on in_valid).
- Stage 1:
  - Captures when in_valid & in_ready. Stores data, jmp, msb = in_data[WIDTH-1], and nz[k] = 8-input OR of byte k, for k = 0..WIDTH/8-1.
  - s1_valid <= in_valid when s1_adv; otherwise it holds.
- Stage 2, when s2_adv:
  - zr = ~|nz; ng = msb.
  - jump = (jmp[2]&ng) | (jmp[1]&zr) | (jmp[0]&~zr&~ng).
  - Loads data, zr, ng, jump; s2_valid <= s1_valid.
- out_valid = s2_valid. While out_valid & !out_ready, all out_* signals are held stable.
- Bubble handling: when stage 2 loads a bubble (s1_valid = 0), out_data, out_zr, out_ng and out_jump keep their previous values.
- Latency and throughput:
  - An accepted word appears on the outputs 2 cycles after acceptance when out_ready is held high.
  - Throughput is 1 word per cycle. There are no bubbles under continuous flow.
- Jump field values:
  - jmp = 3'b000 never jumps.
  - jmp = 3'b111 always jumps.
  - 0x8000 gives ng=1, zr=0. 0x0000 gives ng=0, zr=1.
- Backpressure:
  - With both stages full and out_ready=0, in_ready=0. No word is lost or duplicated.
  - Simultaneous out_ready rising and in_valid: the pipeline shifts and accepts in the same cycle.

Optional Feature:
- Macro: JMP_STATS_EN.
- Defined:
  - Adds input cnt_clr (1 bit) and output taken_cnt (CNT_W bits).
  - taken_cnt increments on each output handshake (out_valid & out_ready) with out_jump=1.
  - Saturates at all-ones.
  - cnt_clr synchronously clears it to 0 and has priority over an increment in the same cycle.
  - Reset value is 0.
- Undefined: neither port exists, and there is no counter logic.

Test Plan:
- Stream 0x0000/jmp=010, 0x8000/jmp=100, 0x0001/jmp=001 with out_ready=1.
  -> Three beats in order at cycles +2, +3, +4. Each beat has zr/ng/jump = 1/0/1, 0/1/1, 0/0/1.
- 0x0100/jmp=010 (high byte only non-zero).
  -> zr=0, jump=0. Confirms the per-byte OR covers both bytes.
- Fill the pipe with 0x0005 then 0x0006 while out_ready=0.
  -> out_valid=1 and out_data=0x0005 held. in_ready=0 on the third cycle.
  -> After out_ready=1, beats 0x0005 then 0x0006 with no loss.
- Pull rst_n low while both stages are valid, then release.
  -> All outputs are 0 during reset. No residual beat. in_ready=1.
- jmp=000 and jmp=111, each applied to 0xFFFF and to 0x0000.
  -> jump = 0, 0, 1, 1.
- With JMP_STATS_EN and CNT_W=2, send five taken beats, then assert cnt_clr.
  -> taken_cnt runs 1, 2, 3, 3, 3, then 0.
